// File: rtl/shared_mem_responder_if.sv
// -----------------------------------------------------------------------------
// shared_mem_if
// Request/response bundle between the three cores and shared_mem_responder.
// Each core owns one lane of the packed buses; lane i = bits [i*W +: W],
// core one sits in lane 0.
//
// Signals:
//   read, write   [2:0]        per-core level requests, held until ack
//   address       [3*ADDR_W]   packed per-core addresses
//   data_in       [3*DATA_W]   packed per-core write data
//   data_out      [3*DATA_W]   packed per-core read data
//   ack           [2:0]        one-cycle acknowledge, one-hot or zero
//   busy                       responder is in its response cycle
//   grant_id      [1:0]        index of the core last granted
//   err_oor                    sticky out-of-range address flag
//   err_proto                  sticky read+write-together flag
//
// Modports: master = core side, slave = responder side.
// -----------------------------------------------------------------------------
interface shared_mem_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [2:0]          read;
    logic [2:0]          write;
    logic [3*ADDR_W-1:0] address;
    logic [3*DATA_W-1:0] data_in;
    logic [3*DATA_W-1:0] data_out;
    logic [2:0]          ack;
    logic                busy;
    logic [1:0]          grant_id;
    logic                err_oor;
    logic                err_proto;

    modport master (
        output read, write, address, data_in,
        input  data_out, ack, busy, grant_id, err_oor, err_proto
    );

    modport slave (
        input  read, write, address, data_in,
        output data_out, ack, busy, grant_id, err_oor, err_proto
    );
endinterface

// File: rtl/shared_mem_responder.sv
// -----------------------------------------------------------------------------
// shared_mem_responder
// Memory-side responder shared by three cores. Arbitrates between pending
// requests, performs one access per grant on a single-port word array and
// returns a one-cycle acknowledge (plus read data on the granted lane) in the
// following cycle. ARB and RESP alternate, so at most one access per two
// cycles.
//
// Ports:
//   clk      system clock, all state on the rising edge
//   rst_n    asynchronous active-low reset
//   mem_bus  shared_mem_if.slave (requests in; data_out/ack/busy/grant_id/
//            err_oor/err_proto out)
//
// Configuration macro:
//   SHARED_MEM_RR_EN  defined   -> round-robin, search starts after the last
//                                  granted core
//                     undefined -> fixed priority core 0 > core 1 > core 2
// -----------------------------------------------------------------------------
module shared_mem_responder #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
) (
    input logic         clk,
    input logic         rst_n,
    shared_mem_if.slave mem_bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ARB  = 1'b0,
        RESP = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          grant_id_q, grant_id_d;
    logic [3*DATA_W-1:0] data_out_q, data_out_d;
    logic                err_oor_q, err_oor_d;
    logic                err_proto_q, err_proto_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [2:0]          pending;
    logic [1:0]          start;
    logic [1:0]          cand;
    logic [1:0]          sel;
    logic                found;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_rd;
    logic                sel_wr;
    logic                in_range;
    logic [IDX_W-1:0]    mem_idx;
    logic [DATA_W-1:0]   rdata;
    logic                mem_we;

    // ------------------------------------------------------------------
    // Arbitration: walk the three cores starting at 'start', take the
    // first one with a pending request.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch
        // can be inferred, even on paths that never assign it again.
        pending = mem_bus.read | mem_bus.write;
`ifdef SHARED_MEM_RR_EN
        start = (grant_id_q == 2'd2) ? 2'd0 : grant_id_q + 2'd1;
`else
        start = 2'd0;
`endif
        sel   = 2'd0;
        found = 1'b0;
        cand  = start;
        for (int k = 0; k < 3; k++) begin
            if (!found && pending[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        end
    end

    // Selected core's lane and request bits.
    always_comb begin
        sel_addr  = mem_bus.address[int'(sel)*ADDR_W +: ADDR_W];
        sel_wdata = mem_bus.data_in[int'(sel)*DATA_W +: DATA_W];
        sel_rd    = mem_bus.read[sel];
        sel_wr    = mem_bus.write[sel];
        in_range  = 32'(sel_addr) < 32'(DEPTH);
        mem_idx   = sel_addr[IDX_W-1:0];
        rdata     = mem_q[mem_idx];
    end

    // ------------------------------------------------------------------
    // FSM next state and registered outputs.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        data_out_d  = data_out_q;
        err_oor_d   = err_oor_q;
        err_proto_d = err_proto_q;
        mem_we      = 1'b0;

        unique case (state_q)
            ARB: begin
                if (found) begin
                    state_d    = RESP;
                    grant_id_d = sel;
                    if (sel_wr) begin
                        // Write wins over a simultaneous read; out-of-range
                        // writes are dropped.
                        mem_we = in_range;
                    end else begin
                        data_out_d[int'(sel)*DATA_W +: DATA_W] =
                            in_range ? rdata : '0;
                    end
                    if (!in_range) err_oor_d = 1'b1;
                    if (sel_rd && sel_wr) err_proto_d = 1'b1;
                end
            end
            RESP: state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB;
            grant_id_q  <= 2'd2;
            data_out_q  <= '0;
            err_oor_q   <= 1'b0;
            err_proto_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            data_out_q  <= data_out_d;
            err_oor_q   <= err_oor_d;
            err_proto_q <= err_proto_d;
        end
    end

    // NOTE: the array has no reset so it maps onto plain RAM; rst_n only
    // gates the write enable so an edge during reset commits nothing.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) mem_q[mem_idx] <= sel_wdata;
    end

    // ack and busy decode straight from state so reset clears them at once.
    assign mem_bus.ack       = (state_q == RESP) ? (3'b001 << grant_id_q) : 3'b000;
    assign mem_bus.busy      = (state_q == RESP);
    assign mem_bus.grant_id  = grant_id_q;
    assign mem_bus.data_out  = data_out_q;
    assign mem_bus.err_oor   = err_oor_q;
    assign mem_bus.err_proto = err_proto_q;

endmodule

// File: tb/tb_shared_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_shared_mem_responder
// Directed bench: a table of single accesses with hand-computed results,
// followed by hand-written sequences for reset during RESP, simultaneous
// requests and fixed-priority starvation.
// -----------------------------------------------------------------------------
module tb_shared_mem_responder;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    shared_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    shared_mem_responder #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mem_bus(mem_bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          core;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        upd;       // lane expected to take exp_rdata
        logic [15:0] exp_rdata;
        logic        exp_oor;
        logic        exp_proto;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    logic [15:0] lanes [3];

    // One access from a given core; starts in ARB, returns ack latency in
    // cycles (-1 on timeout) and the ack vector seen.
    task automatic access(input int core, input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          output int lat, output logic [2:0] ack_seen);
        for (int i = 0; i < 4 && mem_bus.busy; i++) begin
            @(posedge clk); #1;
        end
        mem_bus.read[core]  = rd;
        mem_bus.write[core] = wr;
        mem_bus.address[core*ADDR_W +: ADDR_W] = addr;
        mem_bus.data_in[core*DATA_W +: DATA_W] = wdata;
        lat = -1;
        ack_seen = 3'b000;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (mem_bus.ack[core]) begin
                lat = c;
                ack_seen = mem_bus.ack;
                break;
            end
        end
        mem_bus.read[core]  = 1'b0;
        mem_bus.write[core] = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [2:0]  ack_seen;
        logic [2:0]  exp_ack [6];
        int          n2;
        int          cnt;

        mem_bus.read    = '0;
        mem_bus.write   = '0;
        mem_bus.address = '0;
        mem_bus.data_in = '0;
        for (int i = 0; i < 3; i++) lanes[i] = 16'h0;

        // Stimulus table
        vecs[0]  = '{0, 1'b0, 1'b1, 16'd5,   16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{0, 1'b1, 1'b0, 16'd5,   16'h0000, 1'b1, 16'hABCD, 1'b0, 1'b0};
        vecs[2]  = '{1, 1'b0, 1'b1, 16'd44,  16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[3]  = '{1, 1'b1, 1'b0, 16'd44,  16'h0000, 1'b1, 16'h5555, 1'b0, 1'b0};
        vecs[4]  = '{1, 1'b0, 1'b1, 16'd300, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[5]  = '{1, 1'b1, 1'b0, 16'd300, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6]  = '{1, 1'b1, 1'b0, 16'd44,  16'h0000, 1'b1, 16'h5555, 1'b1, 1'b0};
        vecs[7]  = '{2, 1'b1, 1'b1, 16'd7,   16'h00FF, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{2, 1'b1, 1'b0, 16'd7,   16'h0000, 1'b1, 16'h00FF, 1'b1, 1'b1};
        vecs[9]  = '{0, 1'b0, 1'b1, 16'd255, 16'hBEEF, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[10] = '{0, 1'b1, 1'b0, 16'd255, 16'h0000, 1'b1, 16'hBEEF, 1'b1, 1'b1};
        vecs[11] = '{0, 1'b0, 1'b1, 16'd0,   16'h1111, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[12] = '{2, 1'b0, 1'b1, 16'd256, 16'hCAFE, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[13] = '{2, 1'b1, 1'b0, 16'd0,   16'h0000, 1'b1, 16'h1111, 1'b1, 1'b1};
        vecs[14] = '{0, 1'b0, 1'b1, 16'd23,  16'h2323, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[15] = '{1, 1'b1, 1'b0, 16'd23,  16'h0000, 1'b1, 16'h2323, 1'b1, 1'b1};

        // Reset state
        #12;
        check("rst_ack",       64'(mem_bus.ack),       64'h0);
        check("rst_busy",      64'(mem_bus.busy),      64'h0);
        check("rst_grant_id",  64'(mem_bus.grant_id),  64'h2);
        check("rst_data_out",  64'(mem_bus.data_out),  64'h0);
        check("rst_err_oor",   64'(mem_bus.err_oor),   64'h0);
        check("rst_err_proto", 64'(mem_bus.err_proto), 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven single accesses
        for (int v = 0; v < NVEC; v++) begin
            access(vecs[v].core, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata,
                   lat, ack_seen);
            if (vecs[v].upd) lanes[vecs[v].core] = vecs[v].exp_rdata;
            check($sformatf("v%0d_latency", v), 64'(lat), 64'd1);
            check($sformatf("v%0d_ack", v), 64'(ack_seen), 64'(3'b001 << vecs[v].core));
            check($sformatf("v%0d_grant_id", v), 64'(mem_bus.grant_id), 64'(vecs[v].core));
            check($sformatf("v%0d_data_out", v), 64'(mem_bus.data_out),
                  64'({lanes[2], lanes[1], lanes[0]}));
            check($sformatf("v%0d_err_oor", v), 64'(mem_bus.err_oor), 64'(vecs[v].exp_oor));
            check($sformatf("v%0d_err_proto", v), 64'(mem_bus.err_proto), 64'(vecs[v].exp_proto));
        end

        // Reset asserted during RESP: outputs clear without a clock edge
        for (int i = 0; i < 4 && mem_bus.busy; i++) begin
            @(posedge clk); #1;
        end
        mem_bus.address[1*ADDR_W +: ADDR_W] = 16'd5;
        mem_bus.read[1] = 1'b1;
        @(posedge clk); #1;
        check("resp_ack_before_rst",  64'(mem_bus.ack),  64'(3'b010));
        check("resp_busy_before_rst", 64'(mem_bus.busy), 64'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_ack",       64'(mem_bus.ack),       64'h0);
        check("async_rst_busy",      64'(mem_bus.busy),      64'h0);
        check("async_rst_err_oor",   64'(mem_bus.err_oor),   64'h0);
        check("async_rst_err_proto", 64'(mem_bus.err_proto), 64'h0);
        check("async_rst_grant_id",  64'(mem_bus.grant_id),  64'h2);
        check("async_rst_data_out",  64'(mem_bus.data_out),  64'h0);
        mem_bus.read[1] = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        #3;

        // All three cores read address 23 together, held until ack
        exp_ack = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
        for (int i = 0; i < 3; i++) mem_bus.address[i*ADDR_W +: ADDR_W] = 16'd23;
        mem_bus.read = 3'b111;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check($sformatf("simul_ack_c%0d", c + 1), 64'(mem_bus.ack), 64'(exp_ack[c]));
            if (exp_ack[c] != 3'b000) begin
                check($sformatf("simul_grant_c%0d", c + 1), 64'(mem_bus.grant_id), 64'(c / 2));
            end
            mem_bus.read = mem_bus.read & ~mem_bus.ack;
        end
        mem_bus.read = 3'b000;
        check("simul_data_out", 64'(mem_bus.data_out), 64'({16'h2323, 16'h2323, 16'h2323}));

        // Cores 0 and 2 request continuously for 20 cycles
        mem_bus.address[0*ADDR_W +: ADDR_W] = 16'd5;
        mem_bus.address[2*ADDR_W +: ADDR_W] = 16'd7;
        mem_bus.read[0] = 1'b1;
        mem_bus.read[2] = 1'b1;
        n2 = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (mem_bus.ack[2]) n2++;
        end
`ifdef SHARED_MEM_RR_EN
        check("rr_core2_served", 64'(n2 > 0), 64'h1);
`else
        check("fixed_core2_starved", 64'(n2), 64'h0);
`endif
        // Release core 0 right after one of its acks
        for (int i = 0; i < 4 && !mem_bus.ack[0]; i++) begin
            @(posedge clk); #1;
        end
        check("release_on_core0_ack", 64'(mem_bus.ack), 64'(3'b001));
        mem_bus.read[0] = 1'b0;
        cnt = -1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (mem_bus.ack[2]) begin
                cnt = c;
                break;
            end
        end
        mem_bus.read[2] = 1'b0;
        check("core2_ack_after_release", 64'(cnt), 64'd2);
        check("final_data_out", 64'(mem_bus.data_out), 64'({16'h00FF, 16'h2323, 16'hABCD}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
